frame_checker: RTL and testbench
================================

Name: frame_checker

Overview:
- Streaming sink that sits directly downstream of the frame generator's 16-bit AXI-Stream egress.
- Parses each frame into header fields, byte-sums the payload, and validates tlast position against the length field.
- Exposes latched results and statistics through an 8-bit Avalon-MM slave, so software can compare them with the generator's checksum.

Parameters:
- CNT_W, 16, width of frame/error counters (8..16).
- MAX_PAYLOAD, 1500, payload length above which a frame is flagged oversize (still consumed).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ingress_port_tdata  in  16  beat; tdata[15:8] is the earlier byte on the wire
- ingress_port_tvalid  in  1  beat valid
- ingress_port_tlast  in  1  last beat of frame
- ingress_port_tready  out  1  sink ready
- chipselect  in  1  Avalon select
- read  in  1  Avalon read
- write  in  1  Avalon write
- address  in  8  Avalon byte address
- writedata  in  8  Avalon write data
- readdata  out  8  Avalon read data, registered
- frame_done  out  1  one-cycle pulse after any frame ends (good or bad)
- frame_err  out  1  valid with frame_done; 1 = frame was bad

Behaviour:
- Reset values: tready=0, readdata=0, frame_done=0, frame_err=0. All shadow registers, counters and the checksum accumulator are 0; FSM is in HDR with beat=0.
- tready goes to 1 on the first cycle after reset deasserts. A beat transfers only when tvalid && tready.
- Byte n of the frame: header beat k carries bytes 2k (tdata[15:8]) and 2k+1 (tdata[7:0]).
- Length = {byte13, byte12}, little-endian.
- Expected payload beats P = ceil(len/2).
- FSM HDR:
  - Capture bytes 0..15 into working registers. Reset the accumulator on beat 0.
  - tlast on beat < 7: runt; go to END with error.
  - tlast on beat 7: good if len==0, otherwise a length error.
  - Beat 7 without tlast: if len==0, length error → DRAIN; else → PAY.
- FSM PAY:
  - For each beat, add tdata[15:8] to the 32-bit accumulator. Add tdata[7:0] too, unless this is the final beat and len is odd.
  - Beat counter is 16-bit.
  - tlast on payload beat P: good → END.
  - tlast before beat P: length error → END.
  - Beat P without tlast: length error → DRAIN.
- FSM DRAIN: accept and discard beats until tlast, then → END.
- FSM END (1 cycle): tready=0.
  - Pulse frame_done.
  - If good: copy working fields and the accumulator into shadow registers in the same cycle, and increment frame_cnt.
  - If bad: increment err_cnt; shadows unchanged.
  - Oversize (len > MAX_PAYLOAD) counts as an error.
  - Next state: HDR.
- Counters wrap modulo 2^CNT_W. Accumulator wraps modulo 2^32.
- Register map (R unless noted):
  - 0-5 dst MAC
  - 6-11 src MAC
  - 12-13 length
  - 14-15 type
  - 16-19 checksum LSB first
  - 20-21 frame_cnt
  - 22-23 err_cnt
  - 24 status: bit0 in-frame (FSM≠HDR or beat≠0), bit1 last frame bad
  - 25W: any write clears frame_cnt, err_cnt and status bit1
  - Unmapped addresses read 0.
- readdata is updated one cycle after chipselect&&read; 0 when not reading.
- Clear write in the same cycle as an END increment: the clear wins and the counter ends at 0.
- Reset mid-frame: the partial frame is discarded and no counters change. The next beat is treated as header beat 0.

Optional Feature:
- Macro: FRAME_CHECKER_BACKPRESSURE_EN.
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset) advances every cycle.
  - tready = lfsr[1:0]!=0 (about 75% duty) in HDR/PAY/DRAIN, still 0 in END and reset.
  - Register 26 reads lfsr; a write to 26 reseeds it (0 maps to 8'hA5).
- Undefined: tready is constant 1 except in END/reset; register 26 reads 0.

Test Plan:
- Frame dst 01..06, src 0A..0F, len 4, type 0800, payload beats 1122,3344, tlast on beat 10 → frame_done with err=0; reg16-19 = 0xAA,0,0,0; frame_cnt=1; reg12=04, reg14=08.
- len 3, payload beats 10FF,2099 with tlast on second → checksum 0x10+0xFF+0x20=0x12F (0x99 excluded); frame good.
- len 6 but tlast on payload beat 2 → frame_err=1, err_cnt=1, shadows keep previous values.
- len 2, four payload beats with tlast on the fourth → DRAIN consumes all beats, err_cnt+1, next frame parses correctly.
- Runt: tlast on header beat 3 → error; reset asserted mid-PAY → counters unchanged and the following good frame gives frame_cnt+1.
- Write reg25 in the same cycle a good frame's END occurs → frame_cnt=0. With the feature defined, sweep tvalid randomly → checksum matches the unthrottled run.

Source files
------------

// File: rtl/frame_checker_if.sv
// Ingress AXI-Stream beat channel and 8-bit Avalon-MM register port of frame_checker.
interface frame_checker_if;
   logic [15:0] ingress_port_tdata;
   logic        ingress_port_tvalid;
   logic        ingress_port_tlast;
   logic        ingress_port_tready;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [7:0]  address;
   logic [7:0]  writedata;
   logic [7:0]  readdata;

   modport slave (
      input  ingress_port_tdata, ingress_port_tvalid, ingress_port_tlast,
      output ingress_port_tready,
      input  chipselect, read, write, address, writedata,
      output readdata
   );

   modport master (
      output ingress_port_tdata, ingress_port_tvalid, ingress_port_tlast,
      input  ingress_port_tready,
      output chipselect, read, write, address, writedata,
      input  readdata
   );
endinterface

// File: rtl/frame_checker.sv
// Frame checker: parses 16-byte headers, byte-sums payload, checks tlast vs length, exposes results over Avalon.
// Optional FRAME_CHECKER_BACKPRESSURE_EN adds LFSR-driven tready throttling and a reseedable LFSR at register 26.
module frame_checker #(
   parameter int CNT_W       = 16,
   parameter int MAX_PAYLOAD = 1500
) (
   input  logic           clk,
   input  logic           reset,
   frame_checker_if.slave bus,
   output logic           frame_done,
   output logic           frame_err
);

   typedef enum logic [1:0] {S_HDR, S_PAY, S_DRAIN, S_END} state_t;

   localparam logic [16:0] L_MAX = 17'(MAX_PAYLOAD);

   state_t            r_state, w_next;
   logic [15:0]       r_beat;
   logic [7:0]        r_hdr [16];
   logic [7:0]        r_sh  [16];
   logic [31:0]       r_acc, r_sh_sum;
   logic [CNT_W-1:0]  r_frame_cnt, r_err_cnt;
   logic              r_bad, r_last_bad, r_live;
   logic [7:0]        r_readdata, w_rd;
   logic              w_xfer, w_tready, w_flag_err, w_final, w_oversize, w_good;
   logic              w_clr, w_in_frame, w_bp_ok;
   logic [15:0]       w_len, w_plen, w_pnum, w_fc, w_ec;

   assign w_len      = {r_hdr[13], r_hdr[12]};
   assign w_plen     = 16'(({1'b0, w_len} + 17'd1) >> 1);
   assign w_pnum     = r_beat + 16'd1;
   assign w_final    = (w_pnum == w_plen);
   assign w_oversize = ({1'b0, w_len} > L_MAX);
   assign w_good     = !(r_bad || w_oversize);
   assign w_xfer     = bus.ingress_port_tvalid && w_tready;
   assign w_clr      = bus.chipselect && bus.write && (bus.address == 8'd25);
   assign w_in_frame = (r_state != S_HDR) || (r_beat != '0);
   assign w_fc       = 16'(r_frame_cnt);
   assign w_ec       = 16'(r_err_cnt);

   assign bus.ingress_port_tready = w_tready;
   assign bus.readdata            = r_readdata;

`ifdef FRAME_CHECKER_BACKPRESSURE_EN
   logic [7:0] r_lfsr;
   logic       w_fb;
   assign w_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_bp_ok = (r_lfsr[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (reset)
         r_lfsr <= 8'hA5;
      else if (bus.chipselect && bus.write && (bus.address == 8'd26))
         r_lfsr <= (bus.writedata == 8'h00) ? 8'hA5 : bus.writedata;
      else
         r_lfsr <= {r_lfsr[6:0], w_fb};
   end
`else
   logic w_unused_wdata;
   assign w_unused_wdata = ^bus.writedata;
   assign w_bp_ok        = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_HDR;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_flag_err = 1'b0;
      unique case (r_state)
         S_HDR: if (w_xfer) begin
            if (bus.ingress_port_tlast) begin
               // beat 7 with tlast is only good for a zero-length frame
               w_next     = S_END;
               w_flag_err = (r_beat != 16'd7) || (w_len != '0);
            end else if (r_beat == 16'd7) begin
               if (w_len == '0) begin
                  w_flag_err = 1'b1;
                  w_next     = S_DRAIN;
               end else begin
                  w_next = S_PAY;
               end
            end
         end
         S_PAY: if (w_xfer) begin
            if (bus.ingress_port_tlast) begin
               w_next     = S_END;
               w_flag_err = !w_final;
            end else if (w_final) begin
               w_flag_err = 1'b1;
               w_next     = S_DRAIN;
            end
         end
         S_DRAIN: if (w_xfer && bus.ingress_port_tlast) w_next = S_END;
         S_END:   w_next = S_HDR;
         default: w_next = S_HDR;
      endcase
   end

   always_comb begin
      w_tready   = 1'b0;
      frame_done = 1'b0;
      frame_err  = 1'b0;
      if (r_state == S_END) begin
         frame_done = 1'b1;
         frame_err  = !w_good;
      end else begin
         w_tready = r_live && w_bp_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_live      <= 1'b0;
         r_beat      <= '0;
         r_acc       <= '0;
         r_sh_sum    <= '0;
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
         r_bad       <= 1'b0;
         r_last_bad  <= 1'b0;
         for (int unsigned i = 0; i < 16; i++) begin
            r_hdr[i] <= '0;
            r_sh[i]  <= '0;
         end
      end else begin
         r_live <= 1'b1;
         unique case (r_state)
            S_HDR: if (w_xfer) begin
               r_hdr[{r_beat[2:0], 1'b0}] <= bus.ingress_port_tdata[15:8];
               r_hdr[{r_beat[2:0], 1'b1}] <= bus.ingress_port_tdata[7:0];
               r_beat <= (r_beat == 16'd7) ? '0 : r_beat + 16'd1;
               if (r_beat == '0) r_acc <= '0;
            end
            S_PAY: if (w_xfer) begin
               // odd length: the low byte of the final beat is padding
               r_acc  <= r_acc + {24'd0, bus.ingress_port_tdata[15:8]}
                               + ((w_final && w_len[0]) ? '0 : {24'd0, bus.ingress_port_tdata[7:0]});
               r_beat <= r_beat + 16'd1;
            end
            S_END: begin
               r_beat     <= '0;
               r_bad      <= 1'b0;
               r_last_bad <= !w_good;
               if (w_good) begin
                  for (int unsigned i = 0; i < 16; i++) r_sh[i] <= r_hdr[i];
                  r_sh_sum    <= r_acc;
                  r_frame_cnt <= r_frame_cnt + 1'b1;
               end else begin
                  r_err_cnt <= r_err_cnt + 1'b1;
               end
            end
            default: ;
         endcase
         if (w_flag_err) r_bad <= 1'b1;
         if (w_clr) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_last_bad  <= 1'b0;
         end
      end
   end

   always_comb begin
      w_rd = '0;
      if (bus.address < 8'd16) begin
         w_rd = r_sh[bus.address[3:0]];
      end else begin
         case (bus.address)
            8'd16: w_rd = r_sh_sum[7:0];
            8'd17: w_rd = r_sh_sum[15:8];
            8'd18: w_rd = r_sh_sum[23:16];
            8'd19: w_rd = r_sh_sum[31:24];
            8'd20: w_rd = w_fc[7:0];
            8'd21: w_rd = w_fc[15:8];
            8'd22: w_rd = w_ec[7:0];
            8'd23: w_rd = w_ec[15:8];
            8'd24: w_rd = {6'd0, r_last_bad, w_in_frame};
`ifdef FRAME_CHECKER_BACKPRESSURE_EN
            8'd26: w_rd = r_lfsr;
`endif
            default: w_rd = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)                             r_readdata <= '0;
      else if (bus.chipselect && bus.read)   r_readdata <= w_rd;
      else                                   r_readdata <= '0;
   end

endmodule

// File: tb/tb_frame_checker.sv
// Directed self-checking bench for frame_checker: register table after a reference frame plus multi-cycle corner sequences.
module tb_frame_checker;

   logic clk = 1'b0;
   logic reset;
   logic frame_done, frame_err;

   frame_checker_if bus();

   frame_checker #(.CNT_W(16), .MAX_PAYLOAD(1500)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] exp;
   } reg_vec_t;

   int          n_chk  = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   int          exp_done = 0;
   logic        last_err = 1'b0;
   logic [15:0] fr [16];
   reg_vec_t    tab [28];

   always @(negedge clk) begin
      if (frame_done) begin
         done_cnt = done_cnt + 1;
         last_err = frame_err;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic av_read(input logic [7:0] a, output logic [7:0] d);
      bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
      @(negedge clk);
      d = bus.readdata;
      bus.chipselect = 1'b0; bus.read = 1'b0;
   endtask

   task automatic av_write(input logic [7:0] a, input logic [7:0] d);
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write = 1'b0;
   endtask

   task automatic reg_chk(input logic [7:0] a, input logic [7:0] exp);
      logic [7:0] d;
      av_read(a, d);
      check($sformatf("reg%0d", a), d, exp);
   endtask

   task automatic send_beat(input logic [15:0] d, input logic l);
      int budget = 200;
`ifdef FRAME_CHECKER_BACKPRESSURE_EN
      repeat ($urandom_range(0, 2)) @(negedge clk);
`endif
      bus.ingress_port_tdata = d; bus.ingress_port_tvalid = 1'b1; bus.ingress_port_tlast = l;
      while (!bus.ingress_port_tready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) check("tready_timeout", 0, 1);
      else @(posedge clk);
      @(negedge clk);
      bus.ingress_port_tvalid = 1'b0; bus.ingress_port_tlast = 1'b0;
   endtask

   task automatic set_hdr(input logic [15:0] len);
      fr[0] = 16'h0102; fr[1] = 16'h0304; fr[2] = 16'h0506;
      fr[3] = 16'h0A0B; fr[4] = 16'h0C0D; fr[5] = 16'h0E0F;
      fr[6] = {len[7:0], len[15:8]};
      fr[7] = 16'h0800;
   endtask

   task automatic send_frame(input int n);
      for (int i = 0; i < n; i++) send_beat(fr[i], i == n - 1);
   endtask

   task automatic send_long(input logic [15:0] len, input int nb, input logic [15:0] d);
      set_hdr(len);
      for (int i = 0; i < 8; i++) send_beat(fr[i], 1'b0);
      for (int i = 0; i < nb; i++) send_beat(d, i == nb - 1);
   endtask

   task automatic frame_result(input string name, input logic exp_err);
      @(negedge clk);
      exp_done++;
      check({name, "_done"}, done_cnt, exp_done);
      check({name, "_err"}, last_err, exp_err);
   endtask

   task automatic wait_ready();
      int w = 0;
      while (!bus.ingress_port_tready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("tready_after_reset", bus.ingress_port_tready, 1);
   endtask

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] rd;
      for (int i = 0; i < 6; i++)  tab[i]     = '{8'(i), 8'(i + 1)};
      for (int i = 0; i < 6; i++)  tab[6 + i] = '{8'(6 + i), 8'(8'h0A + i)};
      tab[12] = '{8'd12, 8'h04}; tab[13] = '{8'd13, 8'h00};
      tab[14] = '{8'd14, 8'h08}; tab[15] = '{8'd15, 8'h00};
      tab[16] = '{8'd16, 8'hAA}; tab[17] = '{8'd17, 8'h00};
      tab[18] = '{8'd18, 8'h00}; tab[19] = '{8'd19, 8'h00};
      tab[20] = '{8'd20, 8'h01}; tab[21] = '{8'd21, 8'h00};
      tab[22] = '{8'd22, 8'h00}; tab[23] = '{8'd23, 8'h00};
      tab[24] = '{8'd24, 8'h00}; tab[25] = '{8'd25, 8'h00};
      tab[26] = '{8'd30, 8'h00}; tab[27] = '{8'd255, 8'h00};

      bus.ingress_port_tdata = '0; bus.ingress_port_tvalid = 1'b0; bus.ingress_port_tlast = 1'b0;
      bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      bus.address = '0; bus.writedata = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tready", bus.ingress_port_tready, 0);
      check("rst_readdata", bus.readdata, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_err", frame_err, 0);
      reset = 1'b0;
      wait_ready();

      // reference good frame, then full register table
      set_hdr(16'd4); fr[8] = 16'h1122; fr[9] = 16'h3344;
      send_frame(10);
      frame_result("f1", 1'b0);
      for (int i = 0; i < 28; i++) begin
         av_read(tab[i].addr, rd);
         check($sformatf("tab_reg%0d", tab[i].addr), rd, tab[i].exp);
      end

      // odd length: low byte of the last beat excluded
      set_hdr(16'd3); fr[8] = 16'h10FF; fr[9] = 16'h2099;
      send_frame(10);
      frame_result("odd", 1'b0);
      reg_chk(8'd16, 8'h2F); reg_chk(8'd17, 8'h01); reg_chk(8'd12, 8'h03); reg_chk(8'd20, 8'h02);

      // early tlast: shadows must keep the odd-length frame
      set_hdr(16'd6); fr[8] = 16'h0101; fr[9] = 16'h0202;
      send_frame(10);
      frame_result("short", 1'b1);
      reg_chk(8'd22, 8'h01); reg_chk(8'd20, 8'h02); reg_chk(8'd16, 8'h2F);
      reg_chk(8'd12, 8'h03); reg_chk(8'd24, 8'h02);

      // overlong frame drained to tlast, then a clean frame
      set_hdr(16'd2); fr[8] = 16'h5555; fr[9] = 16'h6666; fr[10] = 16'h7777; fr[11] = 16'h8888;
      send_frame(12);
      frame_result("long", 1'b1);
      reg_chk(8'd22, 8'h02);
      set_hdr(16'd4); fr[8] = 16'h1122; fr[9] = 16'h3344;
      send_frame(10);
      frame_result("after_drain", 1'b0);
      reg_chk(8'd16, 8'hAA); reg_chk(8'd12, 8'h04); reg_chk(8'd20, 8'h03); reg_chk(8'd24, 8'h00);

      // runt: tlast on header beat 3
      set_hdr(16'd4);
      send_frame(4);
      frame_result("runt", 1'b1);
      reg_chk(8'd22, 8'h03);

      // oversize boundary: 1501 bad, 1500 good
      send_long(16'd1501, 751, 16'h0101);
      frame_result("len1501", 1'b1);
      reg_chk(8'd22, 8'h04); reg_chk(8'd16, 8'hAA);
      send_long(16'd1500, 750, 16'h0101);
      frame_result("len1500", 1'b0);
      reg_chk(8'd16, 8'hDC); reg_chk(8'd17, 8'h05); reg_chk(8'd12, 8'hDC);
      reg_chk(8'd13, 8'h05); reg_chk(8'd20, 8'h04);

      av_write(8'd25, 8'h00);
      reg_chk(8'd20, 8'h00); reg_chk(8'd22, 8'h00); reg_chk(8'd24, 8'h00);

      // reset in the middle of the payload
      set_hdr(16'd4); fr[8] = 16'h1122;
      for (int i = 0; i < 9; i++) send_beat(fr[i], 1'b0);
      reg_chk(8'd24, 8'h01);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wait_ready();
      check("midrst_no_done", done_cnt, exp_done);
      reg_chk(8'd20, 8'h00); reg_chk(8'd22, 8'h00); reg_chk(8'd16, 8'h00);
      set_hdr(16'd4); fr[8] = 16'h1122; fr[9] = 16'h3344;
      send_frame(10);
      frame_result("post_rst", 1'b0);
      reg_chk(8'd20, 8'h01); reg_chk(8'd16, 8'hAA);

      // clear write lands on the END cycle of a good frame
      set_hdr(16'd4); fr[8] = 16'h0102; fr[9] = 16'h0304;
      send_frame(10);
      av_write(8'd25, 8'h00);
      exp_done++;
      check("collide_done", done_cnt, exp_done);
      check("collide_err", last_err, 0);
      reg_chk(8'd20, 8'h00); reg_chk(8'd16, 8'h0A);

`ifdef FRAME_CHECKER_BACKPRESSURE_EN
      av_write(8'd26, 8'h00);
      reg_chk(8'd26, 8'hA5);
      av_write(8'd26, 8'h3C);
      reg_chk(8'd26, 8'h3C);
`else
      av_write(8'd26, 8'hFF);
      reg_chk(8'd26, 8'h00);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
